// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam int DVSR_DEFAULT = 5000000;

    function automatic bcd_t bcd_next(input bcd_t q, input bcd_t max);
        return (q == max) ? 4'd0 : q + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_cnt.sv
// Single BCD digit counter with synchronous clear and carry-out on wrap.
module bcd_cnt
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = 4'd9
)
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output bcd_t q,
    output logic carry
);

    // Carry is combinational so the whole chain ripples within the tick cycle.
    assign carry = inc && (q == MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= 4'd0;
        end else if (clr) begin
            q <= 4'd0;
        end else if (inc) begin
            q <= bcd_next(q, MAX);
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/pause/clear FSM, 0.1 s prescaler, M:SS.T digit
// chain and a lap-freeze display stage.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DVSR = DVSR_DEFAULT
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] d_tenth,
    output logic [3:0] d_sec_lo,
    output logic [3:0] d_sec_hi,
    output logic [3:0] d_min,
    output logic       running,
    output logic       lap_hold,
    output logic       max_tick
);

    localparam int            PW         = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DVSR - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

    state_t        state;
    logic [PW-1:0] presc;
    logic          tick;
    logic          clr_act;

    bcd_t tenth, sec_lo, sec_hi, min_q;
    logic c_tenth, c_sec_lo, c_sec_hi, c_min;

    assign tick    = (state == RUN) && (presc == PRESC_LAST);
    // Clear only acts outside RUN, and there it overrides start_stop.
    assign clr_act = clear && (state != RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!clear && start_stop) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (start_stop) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (clear) begin
                        state <= IDLE;
                    end else if (start_stop) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (clr_act) begin
            presc <= '0;
        end else begin
            case (state)
                RUN:     presc <= tick ? '0 : presc + PRESC_ONE;
                PAUSE:   presc <= presc;
                default: presc <= '0;
            endcase
        end
    end

    bcd_cnt #(.MAX(4'd9)) u_tenth (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_act),
        .inc   (tick),
        .q     (tenth),
        .carry (c_tenth)
    );

    bcd_cnt #(.MAX(4'd9)) u_sec_lo (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_act),
        .inc   (c_tenth),
        .q     (sec_lo),
        .carry (c_sec_lo)
    );

    bcd_cnt #(.MAX(4'd5)) u_sec_hi (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_act),
        .inc   (c_sec_lo),
        .q     (sec_hi),
        .carry (c_sec_hi)
    );

    bcd_cnt #(.MAX(4'd9)) u_min (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_act),
        .inc   (c_sec_hi),
        .q     (min_q),
        .carry (c_min)
    );

    // Display stage: follows the live digits one cycle late unless frozen by lap.
    // Loading on a lap edge captures the pre-increment value when a tick coincides.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_hold <= 1'b0;
            max_tick <= 1'b0;
            d_tenth  <= 4'd0;
            d_sec_lo <= 4'd0;
            d_sec_hi <= 4'd0;
            d_min    <= 4'd0;
        end else begin
            max_tick <= c_min;
            if (clr_act) begin
                lap_hold <= 1'b0;
                d_tenth  <= 4'd0;
                d_sec_lo <= 4'd0;
                d_sec_hi <= 4'd0;
                d_min    <= 4'd0;
            end else begin
                if (lap && lap_hold) begin
                    lap_hold <= 1'b0;
                end else if (lap && (state == RUN)) begin
                    lap_hold <= 1'b1;
                end
                if (!lap_hold || lap) begin
                    d_tenth  <= tenth;
                    d_sec_lo <= sec_lo;
                    d_sec_hi <= sec_hi;
                    d_min    <= min_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with DVSR=2: directed vector table,
// corner-case sequences and random pulses against a tenths-count reference model.
module tb_stopwatch_ctrl;

    localparam int DVSR = 2;
    localparam int WRAP = 6000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic       lap = 1'b0;
    logic [3:0] d_tenth, d_sec_lo, d_sec_hi, d_min;
    logic       running, lap_hold, max_tick;

    int checks = 0;
    int errors = 0;

    typedef enum int {M_IDLE, M_RUN, M_PAUSE} mstate_e;
    mstate_e m_state;
    int      m_phase;
    int      m_t;
    int      m_disp;
    bit      m_lap;
    bit      m_max;

    typedef struct {
        bit ss;
        bit clr;
        bit lp;
        bit running;
        bit lap_hold;
        int shown;
    } vec_t;

    vec_t vt[13];

    always #5 clk = ~clk;

    stopwatch_ctrl #(.DVSR(DVSR)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .d_tenth    (d_tenth),
        .d_sec_lo   (d_sec_lo),
        .d_sec_hi   (d_sec_hi),
        .d_min      (d_min),
        .running    (running),
        .lap_hold   (lap_hold),
        .max_tick   (max_tick)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dut_val();
        return int'(d_min) * 600 + int'(d_sec_hi) * 100 + int'(d_sec_lo) * 10 + int'(d_tenth);
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_phase = 0;
        m_t     = 0;
        m_disp  = 0;
        m_lap   = 1'b0;
        m_max   = 1'b0;
    endtask

    // Elapsed time kept as a tenths count; digits are derived only when compared.
    task automatic model_step(input bit ss, input bit clr, input bit lp);
        bit tick;
        tick = (m_state == M_RUN) && (m_phase == DVSR - 1);
        if (clr && (m_state != M_RUN)) begin
            model_reset();
        end else begin
            m_max = tick && (m_t == WRAP - 1);
            if (!m_lap || lp) m_disp = m_t;
            if (lp && m_lap) m_lap = 1'b0;
            else if (lp && (m_state == M_RUN)) m_lap = 1'b1;
            if (tick) m_t = (m_t + 1) % WRAP;
            if (m_state == M_RUN) m_phase = tick ? 0 : m_phase + 1;
            else if (m_state == M_IDLE) m_phase = 0;
            if (ss) m_state = (m_state == M_RUN) ? M_PAUSE : M_RUN;
        end
    endtask

    task automatic model_check();
        chk("d_tenth",  int'(d_tenth),  m_disp % 10);
        chk("d_sec_lo", int'(d_sec_lo), (m_disp / 10) % 10);
        chk("d_sec_hi", int'(d_sec_hi), (m_disp / 100) % 6);
        chk("d_min",    int'(d_min),    m_disp / 600);
        chk("running",  int'(running),  int'(m_state == M_RUN));
        chk("lap_hold", int'(lap_hold), int'(m_lap));
        chk("max_tick", int'(max_tick), int'(m_max));
    endtask

    task automatic step(input bit ss, input bit clr, input bit lp);
        start_stop = ss;
        clear      = clr;
        lap        = lp;
        @(posedge clk);
        model_step(ss, clr, lp);
        #1;
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
        model_check();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int pulses;
        bit chk_next;
        bit seen100;

        // ss clr lap | running lap_hold shown(tenths)
        vt[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        vt[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vt[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2};
        vt[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2};
        vt[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        vt[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        vt[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0};

        model_reset();
        repeat (2) @(negedge clk);
        model_check();
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            step(vt[i].ss, vt[i].clr, vt[i].lp);
            chk($sformatf("vec%0d_running", i),  int'(running),  int'(vt[i].running));
            chk($sformatf("vec%0d_lap_hold", i), int'(lap_hold), int'(vt[i].lap_hold));
            chk($sformatf("vec%0d_shown", i),    dut_val(),      vt[i].shown);
        end

        // Ten ticks reach 0:01.0; display lags live by one cycle.
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        repeat (21) step(1'b0, 1'b0, 1'b0);
        chk("run_one_second", dut_val(), 10);

        // Pause while prescaler sits at its last value, hold, then resume.
        step(1'b1, 1'b0, 1'b0);
        chk("pause_running", int'(running), 0);
        repeat (11) step(1'b0, 1'b0, 1'b0);
        chk("pause_hold", dut_val(), 11);
        step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("resume_tick", dut_val(), 12);

        // Clear in RUN is ignored; clear with start_stop in PAUSE goes IDLE.
        step(1'b0, 1'b1, 1'b0);
        chk("clear_in_run_running", int'(running), 1);
        chk("clear_in_run_shown", dut_val(), 12);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("clear_wins_running", int'(running), 0);
        chk("clear_wins_shown", dut_val(), 0);

        // Lap freeze at 0:03.4, release shows 0:03.9.
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 200 && m_t != 34; i++) step(1'b0, 1'b0, 1'b0);
        chk("reach_0034", m_t, 34);
        step(1'b0, 1'b0, 1'b1);
        chk("lap_set", int'(lap_hold), 1);
        chk("lap_frozen_start", dut_val(), 34);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        chk("lap_frozen_end", dut_val(), 34);
        step(1'b0, 1'b0, 1'b1);
        chk("lap_release_hold", int'(lap_hold), 0);
        chk("lap_release_shown", dut_val(), 39);

        // Asynchronous reset mid-run with the display frozen.
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 200 && m_t != 55; i++) step(1'b0, 1'b0, 1'b0);
        chk("reach_0055", m_t, 55);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        model_check();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) step(1'b0, 1'b0, 1'b0);

        // Full run to the 9:59.9 wrap.
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        pulses   = 0;
        chk_next = 1'b0;
        seen100  = 1'b0;
        for (int i = 0; i < 12100; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (chk_next) begin
                chk("wrap_shown_zero", dut_val(), 0);
                chk_next = 1'b0;
            end
            if (max_tick) begin
                pulses++;
                chk("max_tick_shown", dut_val(), 5999);
                chk_next = 1'b1;
            end
            if (!seen100 && m_disp == 100) begin
                seen100 = 1'b1;
                chk("carry_sec_lo", int'(d_sec_lo), 0);
                chk("carry_sec_hi", int'(d_sec_hi), 1);
            end
        end
        chk("max_tick_pulses", pulses, 1);

        // Random pulse traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
